// File: rtl/u_thermo_ramp.sv
// u_thermo_ramp
// Moves a binary level toward a commanded target by a fixed step each clock.
// The level is presented both as a binary value and as a thermometer code.
// The level lands exactly on the target, never passing it or wrapping.
// o_done pulses for one cycle in the cycle the target is reached.
//
// Optional feature, selected by the macro THERMO_RETARGET_EN:
//   defined   - o_ready stays high in every state. A command accepted
//               mid-ramp replaces the target and step. The direction is
//               re-evaluated from the current level. The abandoned target
//               produces no o_done.
//   undefined - o_ready is low while ramping, and i_valid is ignored there.
module u_thermo_ramp #(
    parameter int BW = 6
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [BW-1:0]       i_in,
    input  logic [BW-1:0]       i_step,
    output logic [(2**BW)-1:0]  o_out,
    output logic [BW-1:0]       o_level,
    output logic                o_done
);

    // Thermometer width. Levels run 0..TW-1, so the top bit is never set.
    localparam int TW = 2 ** BW;
    // Internal arithmetic width. It has one spare bit, so differences and
    // sums of levels and steps never overflow.
    localparam int LW = BW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] level_q, level_d;
    logic [BW-1:0] tgt_q,   tgt_d;
    logic [BW-1:0] step_q,  step_d;
    logic [TW-1:0] out_q,   out_d;
    logic          done_q,  done_d;
    logic          ready_q, ready_d;

    logic          accept;
    logic          move;
    logic [LW-1:0] lvl_w;
    logic [LW-1:0] tgt_w;
    logic [LW-1:0] next_w;

    // A zero step would stall the ramp forever, so it is promoted to one.
    function automatic logic [BW-1:0] norm_step(input logic [BW-1:0] s);
        return (s == '0) ? BW'(1) : s;
    endfunction

    // Smaller of two widened operands.
    function automatic logic [LW-1:0] min_w(input logic [LW-1:0] a,
                                            input logic [LW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // One ramp step toward the target.
    // The step is clamped to the remaining distance, so the level never
    // passes the target. An equal target returns the level unchanged.
    function automatic logic [LW-1:0] move_toward(input logic [LW-1:0] lvl,
                                                  input logic [LW-1:0] tgt,
                                                  input logic [LW-1:0] stp);
        logic [LW-1:0] res;
        if (tgt > lvl) begin
            res = lvl + min_w(stp, tgt - lvl);
        end else begin
            res = lvl - min_w(stp, lvl - tgt);
        end
        return res;
    endfunction

    // Thermometer code: the low 'lvl' bits set, all others clear.
    function automatic logic [TW-1:0] thermo(input logic [BW-1:0] lvl);
        return ~({TW{1'b1}} << lvl);
    endfunction

    // A command is taken when the source offers it and the block is ready.
    assign accept = i_valid & ready_q;

    // Latch the target and the normalised step whenever a command is accepted.
    always_comb begin
        tgt_d  = tgt_q;
        step_d = step_q;
        if (accept) begin
            tgt_d  = i_in;
            step_d = norm_step(i_step);
        end
    end

    // Next state, level, done pulse, thermometer image and ready flag.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        done_d  = 1'b0;
        move    = 1'b0;

        case (state_q)
            // The level only moves once a command arrives. The step is
            // applied on the accepting edge, so the first change shows in
            // the very next cycle.
            IDLE:      move = accept;
            // While ramping, the level steps every cycle toward the target
            // in tgt_d. With retargeting, a fresh command has already
            // replaced that target here.
            RAMP_UP,
            RAMP_DOWN: move = 1'b1;
            default: begin
                move    = 1'b0;
                state_d = IDLE;
            end
        endcase

        lvl_w  = {1'b0, level_q};
        tgt_w  = {1'b0, tgt_d};
        next_w = move_toward(lvl_w, tgt_w, {1'b0, step_d});

        if (move) begin
            level_d = next_w[BW-1:0];
            if (next_w == tgt_w) begin
                // Target reached, either by this step or because the
                // command matched the current level.
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (tgt_w > lvl_w) begin
                state_d = RAMP_UP;
            end else begin
                state_d = RAMP_DOWN;
            end
        end

        // Both output images come from the same next level, so they
        // always agree.
        out_d = thermo(level_d);

`ifdef THERMO_RETARGET_EN
        ready_d = 1'b1;
`else
        ready_d = (state_d == IDLE);
`endif
    end

    // Register all state and outputs. Reset aborts any ramp at once,
    // with no done pulse.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            level_q <= '0;
            tgt_q   <= '0;
            step_q  <= BW'(1);
            out_q   <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            out_q   <= out_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign o_out   = out_q;
    assign o_level = level_q;
    assign o_done  = done_q;
    assign o_ready = ready_q;

endmodule

// File: tb/tb_u_thermo_ramp.sv
// Testbench for u_thermo_ramp (BW = 6).
// The reference model plans each accepted command as a queue of future
// levels. One level is popped per clock, and the last pop is the done cycle.
// Directed scenarios pin known level sequences; a random phase follows.
`timescale 1ns/1ps
module tb_u_thermo_ramp;

    localparam int BW = 6;
    localparam int TW = 64;
`ifdef THERMO_RETARGET_EN
    localparam bit RETARGET = 1'b1;
`else
    localparam bit RETARGET = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          rstn    = 1'b0;
    logic          i_valid = 1'b0;
    logic [BW-1:0] i_in    = '0;
    logic [BW-1:0] i_step  = '0;
    logic          o_ready;
    logic [TW-1:0] o_out;
    logic [BW-1:0] o_level;
    logic          o_done;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int traj[$];
    int m_level = 0;
    bit m_done  = 1'b0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    u_thermo_ramp #(.BW(BW)) dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_in    (i_in),
        .i_step  (i_step),
        .o_out   (o_out),
        .o_level (o_level),
        .o_done  (o_done)
    );

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] thermo(input int lvl);
        logic [TW-1:0] v;
        v = '0;
        for (int i = 0; i < TW; i++) v[i] = (i < lvl);
        return v;
    endfunction

    // Replace the plan with the sequence of levels from the current level
    // to tgt. A target equal to the current level yields one entry.
    task automatic plan(input int tgt, input int stp);
        int cur;
        int s;
        cur = m_level;
        s   = (stp == 0) ? 1 : stp;
        traj.delete();
        if (tgt == cur) traj.push_back(cur);
        while (cur != tgt) begin
            if (tgt > cur) cur += ((tgt - cur) < s) ? (tgt - cur) : s;
            else           cur -= ((cur - tgt) < s) ? (cur - tgt) : s;
            traj.push_back(cur);
        end
    endtask

    // Reference model: advances on each clock edge and resets asynchronously.
    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                traj.delete();
                m_level = 0;
                m_done  = 1'b0;
            end else begin
                if (i_valid && (traj.size() == 0 || RETARGET))
                    plan(int'(i_in), int'(i_step));
                if (traj.size() != 0) begin
                    m_level = traj.pop_front();
                    m_done  = (traj.size() == 0);
                end else begin
                    m_done = 1'b0;
                end
            end
        end
    end

    // Compare all outputs against the model on every falling edge.
    initial begin
        bit m_ready;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                m_ready = (traj.size() == 0) || RETARGET;
                chk("model_level", TW'(o_level), TW'(m_level));
                chk("model_out",   o_out,        thermo(m_level));
                chk("model_done",  TW'(o_done),  TW'(m_done));
                chk("model_ready", TW'(o_ready), TW'(m_ready));
            end
        end
    end

    // Issue one command from idle; it is accepted at the second rising edge.
    task automatic cmd(input int tgt, input int stp);
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_in    = BW'(tgt);
        i_step  = BW'(stp);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    initial begin
        int dones;
        int r;

        // Reset, then release away from a clock edge.
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rstn   = 1'b1;
        cmp_en = 1'b1;
        #1;
        chk("rst_out",   o_out,        64'h0);
        chk("rst_level", TW'(o_level), 64'd0);
        chk("rst_ready", TW'(o_ready), 64'd1);
        chk("rst_done",  TW'(o_done),  64'd0);

        // 0 -> 5, step 2: levels 2, 4, 5; done with the last one.
        cmd(5, 2);
        @(negedge clk); chk("up5_l1", TW'(o_level), 64'd2); chk("up5_d1", TW'(o_done), 64'd0);
        @(negedge clk); chk("up5_l2", TW'(o_level), 64'd4);
        @(negedge clk); chk("up5_l3", TW'(o_level), 64'd5);
        chk("up5_out", o_out, 64'h1F);
        chk("up5_done", TW'(o_done), 64'd1);
        chk("up5_ready", TW'(o_ready), 64'd1);

        // Jump to the maximum level, then walk down with step 0 (treated as 1).
        cmd(63, 63);
        @(negedge clk); chk("max_level", TW'(o_level), 64'd63);
        chk("max_out", o_out, 64'h7FFF_FFFF_FFFF_FFFF);
        cmd(0, 0);
        dones = 0;
        for (int n = 1; n <= 63; n++) begin
            @(negedge clk);
            if (o_done === 1'b1) dones++;
        end
        chk("down_level", TW'(o_level), 64'd0);
        chk("down_out",   o_out,        64'h0);
        chk("down_ndone", TW'(dones),   64'd1);
        chk("down_dlast", TW'(o_done),  64'd1);

        // A command equal to the current level: no move, done next cycle.
        cmd(17, 63);
        @(negedge clk); chk("to17", TW'(o_level), 64'd17);
        cmd(17, 5);
        @(negedge clk);
        chk("same_level", TW'(o_level), 64'd17);
        chk("same_done",  TW'(o_done),  64'd1);
        chk("same_out",   o_out,        64'h1_FFFF);
        @(negedge clk); chk("same_done_end", TW'(o_done), 64'd0);

        // Mid-ramp command at level 12 of a 0 -> 40 step-4 ramp.
        cmd(0, 63);
        @(negedge clk);
        cmd(40, 4);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("mid_l12", TW'(o_level), 64'd12);
        i_valid = 1'b1; i_in = 6'd3; i_step = 6'd4;
`ifdef THERMO_RETARGET_EN
        @(posedge clk); #1; i_valid = 1'b0;
        @(negedge clk); chk("rt_l8", TW'(o_level), 64'd8); chk("rt_d8", TW'(o_done), 64'd0);
        @(negedge clk); chk("rt_l4", TW'(o_level), 64'd4); chk("rt_d4", TW'(o_done), 64'd0);
        @(negedge clk); chk("rt_l3", TW'(o_level), 64'd3); chk("rt_d3", TW'(o_done), 64'd1);
`else
        repeat (7) @(negedge clk);
        chk("stall_l40",   TW'(o_level), 64'd40);
        chk("stall_done",  TW'(o_done),  64'd1);
        chk("stall_ready", TW'(o_ready), 64'd1);
        @(posedge clk); #1; i_valid = 1'b0;
        @(negedge clk); chk("stall_l36", TW'(o_level), 64'd36);
        repeat (9) @(negedge clk);
        chk("stall_l3", TW'(o_level), 64'd3);
        chk("stall_d3", TW'(o_done),  64'd1);
`endif

        // Reset pulsed at level 20 mid-ramp; then a command on the first edge after release.
        cmd(0, 63);
        @(negedge clk);
        cmd(40, 4);
        repeat (5) @(negedge clk);
        chk("abort_l20", TW'(o_level), 64'd20);
        #2 rstn = 1'b0;
        #1;
        chk("abort_level", TW'(o_level), 64'd0);
        chk("abort_out",   o_out,        64'h0);
        chk("abort_done",  TW'(o_done),  64'd0);
        chk("abort_ready", TW'(o_ready), 64'd1);
        @(negedge clk); #2;
        i_valid = 1'b1; i_in = 6'd9; i_step = 6'd9;
        rstn = 1'b1;
        @(posedge clk); #1; i_valid = 1'b0;
        @(negedge clk);
        chk("first_l9", TW'(o_level), 64'd9);
        chk("first_d9", TW'(o_done),  64'd1);

        // Random commands, occasionally interrupted by a reset pulse.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            rstn    = ($urandom_range(0, 399) != 0);
            i_valid = ($urandom_range(0, 3) == 0);
            i_in    = BW'($urandom);
            r       = $urandom_range(0, 9);
            if (r == 0)      i_step = '0;
            else if (r == 1) i_step = BW'($urandom_range(8, 63));
            else             i_step = BW'($urandom_range(1, 7));
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
        rstn    = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/u_thermo_ramp.md
U_THERMO_RAMP -- requirements
Module: u_thermo_ramp

Interface
REQ-001 Parameter BW, default 6, SHALL set the binary level width; the thermometer width TW = 2**BW is derived, not a parameter.
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 i_valid  input  1  SHALL mark a valid ramp command.
REQ-005 o_ready  output  1  SHALL indicate a command is accepted when i_valid=1 at the same edge.
REQ-006 i_in  input  BW  SHALL be the target level of the command.
REQ-007 i_step  input  BW  SHALL be the per-cycle step size of the command.
REQ-008 o_out  output  TW  SHALL be the registered thermometer code of the current level: bits [level-1:0]=1, all others 0.
REQ-009 o_level  output  BW  SHALL be the registered binary current level.
REQ-010 o_done  output  1  SHALL pulse for one cycle when level reaches target.

Function
REQ-011 Acceptance SHALL occur at a rising edge with i_valid=1 and o_ready=1; i_in and i_step SHALL be latched then.
REQ-012 A latched i_step of 0 SHALL be treated as 1.
REQ-013 FSM states SHALL be IDLE, RAMP_UP, RAMP_DOWN; o_ready SHALL be 1 in IDLE.
REQ-014 On acceptance with target>level, next state SHALL be RAMP_UP; with target<level, RAMP_DOWN; with target==level, state SHALL stay IDLE and o_done SHALL pulse in the next cycle.
REQ-015 In RAMP_UP, each cycle level SHALL become level+min(step, target-level); in RAMP_DOWN, level-min(step, level-target). No overshoot, no wrap-around.
REQ-016 The first level change SHALL be visible in the cycle after acceptance.
REQ-017 In the cycle where level becomes equal to target, state SHALL become IDLE, o_done SHALL be 1 and o_ready SHALL be 1.
REQ-018 o_out and o_level SHALL update in the same cycle and always be consistent; o_out[TW-1] SHALL never be 1, because the maximum level is TW-1.
REQ-019 Level range SHALL be 0..TW-1; arithmetic SHALL use BW+1 bits internally so that min() and differences never overflow.
REQ-020 o_done SHALL be 0 in every cycle other than those defined in REQ-014 and REQ-017.

Reset
REQ-021 While i_rstn=0, the block SHALL hold: state IDLE, level 0, o_out all 0, o_level 0, o_done 0, o_ready 1, latched target 0, latched step 1.
REQ-022 Reset asserted mid-ramp SHALL abort the ramp immediately and asynchronously, with no o_done pulse.
REQ-023 The first command SHALL be accepted at the first rising edge after i_rstn deasserts.

Configuration
REQ-024 Macro THERMO_RETARGET_EN defined: o_ready SHALL be 1 in every state, and a command accepted mid-ramp SHALL replace target and step. The direction SHALL be re-evaluated against the current level per REQ-014, with no o_done for the abandoned target.
REQ-025 Macro THERMO_RETARGET_EN undefined: o_ready SHALL be 0 in RAMP_UP and RAMP_DOWN, and i_valid SHALL be ignored there.

Verification
REQ-026 Reset, BW=6: after release, o_out=64'h0, o_level=0, o_ready=1, o_done=0.
REQ-027 From level 0, command i_in=5, i_step=2 -> o_level 2,4,5 over the next 3 cycles; o_out=64'h1F and o_done=1 in the third cycle.
REQ-028 From level 63, command i_in=0, i_step=0 -> step 1, 63 cycles down to 0, o_out ends 64'h0, exactly one o_done.
REQ-029 Command i_in equal to the current level (e.g., 17) -> no level change, o_done one cycle after acceptance, o_out=64'h1_FFFF.
REQ-030 Mid-ramp (0->40, step 4, at level 12) new command i_in=3: with THERMO_RETARGET_EN, the level goes 8,4,3 and o_done occurs once; without it, the command is stalled until level 40 with o_done.
REQ-031 i_rstn pulsed low at level 20 during a ramp -> o_out=0 and o_level=0 immediately, no o_done.
